// File: rtl/tester_ex1_2_stim_if.sv
// Output bundle of the adder-bench stimulus generator: DUT reset, operands and phase flags.
interface tester_ex1_2_stim_if #(
  parameter int A = 8,
  parameter int B = 8
);
  logic         o_resetn;
  logic [A-1:0] op_a;
  logic [B-1:0] op_b;
  logic         o_valid;
  logic         o_done;

  modport master (output o_resetn, op_a, op_b, o_valid, o_done);
  modport slave  (input  o_resetn, op_a, op_b, o_valid, o_done);
endinterface

// File: rtl/tester_ex1_2_stim.sv
// Self-running stimulus for the unsigned adder bench: DUT reset hold, eight
// directed corner vectors, then NUM_RANDOM pairs from two Galois LFSRs.
module tester_ex1_2_stim #(
  parameter int          A          = 8,
  parameter int          B          = 8,
  parameter int          ADDER_0    = A + 1,
  parameter int          RST_CYCLES = 4,
  parameter int          NUM_RANDOM = 64,
  parameter logic [31:0] SEED_A     = 32'h0000_0001,
  parameter logic [31:0] SEED_B     = 32'h0000_ACE1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  tester_ex1_2_stim_if.master   stim
);
  localparam int CMAX = (RST_CYCLES > NUM_RANDOM) ? ((RST_CYCLES > 8) ? RST_CYCLES : 8)
                                                  : ((NUM_RANDOM > 8) ? NUM_RANDOM : 8);
  localparam int          CW   = $clog2(CMAX + 1);
  localparam logic [31:0] POLY = 32'h8020_0003;

  if (A < 1 || A > 32 || B < 1 || B > 32 || ADDER_0 < 1 || RST_CYCLES < 1 ||
      NUM_RANDOM < 1 || SEED_A == 32'h0 || SEED_B == 32'h0) begin : g_param_chk
    $error("tester_ex1_2_stim: illegal parameter set");
  end

  typedef enum logic [1:0] {HOLD, DIRECTED, RANDOM, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic           resetn_q, resetn_d;
  logic [A-1:0]   op_a_q, op_a_d;
  logic [B-1:0]   op_b_q, op_b_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [A+B-1:0] directed_vec(input logic [2:0] idx);
    logic [A-1:0] a;
    logic [B-1:0] b;
    a = '0;
    b = '0;
    case (idx)
      3'd1: b = B'(1);
      3'd2: a = A'(1);
      3'd3: a = '1;
      3'd4: b = '1;
      3'd5: begin a = '1;     b = B'(1); end
      3'd6: begin a = A'(1);  b = '1;    end
      3'd7: begin a = '1;     b = '1;    end
      default: ;
    endcase
    return {a, b};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    resetn_d = resetn_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    valid_d  = valid_q;
    done_d   = done_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d          = DIRECTED;
          cnt_d            = '0;
          resetn_d         = 1'b1;
          {op_a_d, op_b_d} = directed_vec(3'd0);
          valid_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIRECTED: begin
        // cnt_q is the index of the vector currently on the outputs
        if (cnt_q == CW'(7)) begin
          state_d  = RANDOM;
          cnt_d    = CW'(1);
          op_a_d   = lfsr_a_q[A-1:0];
          op_b_d   = lfsr_b_q[B-1:0];
          lfsr_a_d = lfsr_step(lfsr_a_q);
          lfsr_b_d = lfsr_step(lfsr_b_q);
        end else begin
          cnt_d            = cnt_q + 1'b1;
          {op_a_d, op_b_d} = directed_vec(cnt_q[2:0] + 3'd1);
        end
      end
      RANDOM: begin
        // cnt_q counts random vectors already issued, including the one on the outputs
        if (cnt_q == CW'(NUM_RANDOM)) begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          op_a_d   = lfsr_a_q[A-1:0];
          op_b_d   = lfsr_b_q[B-1:0];
          lfsr_a_d = lfsr_step(lfsr_a_q);
          lfsr_b_d = lfsr_step(lfsr_b_q);
        end
      end
      DONE: ;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      resetn_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      resetn_q <= resetn_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign stim.o_resetn = resetn_q;
  assign stim.op_a     = op_a_q;
  assign stim.op_b     = op_b_q;
  assign stim.o_valid  = valid_q;
  assign stim.o_done   = done_q;
endmodule

// File: tb/tb_tester_ex1_2_stim.sv
// Bench for tester_ex1_2_stim: two configurations checked every cycle against a
// sequence model indexed by edges since reset release.
module tb_tester_ex1_2_stim;
  localparam int RC0 = 4, NR0 = 64;
  localparam int RC1 = 2, NR1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tester_ex1_2_stim_if #(.A(8), .B(8))  if0 ();
  tester_ex1_2_stim_if #(.A(4), .B(12)) if1 ();

  tester_ex1_2_stim #(.A(8), .B(8), .RST_CYCLES(RC0), .NUM_RANDOM(NR0)) dut0 (
    .i_clk(clk), .i_reset(rst), .stim(if0.master));
  tester_ex1_2_stim #(.A(4), .B(12), .RST_CYCLES(RC1), .NUM_RANDOM(NR1)) dut1 (
    .i_clk(clk), .i_reset(rst), .stim(if1.master));

  int checks = 0;
  int failures = 0;
  int k = 0;
  logic armed = 1'b0;
  int vcnt0 = 0, vcnt1 = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        resetn;
    logic        valid;
    logic        done;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h k=%0d t=%0t", nm, act, exp, k, $time);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // i-th issued vector: directed table, then LFSR pairs starting from the seeds
  function automatic logic [63:0] vec(input int aw, input int bw, input int i);
    logic [31:0] ma, mb, sa, sb;
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    ma = mask(aw);
    mb = mask(bw);
    ta = '{0, 0, 1, ma, 0, ma, 1, ma};
    tb = '{0, 1, 0, 0, mb, 1, mb, mb};
    if (i < 8) return {ta[i], tb[i]};
    sa = 32'h0000_0001;
    sb = 32'h0000_ACE1;
    for (int j = 0; j < i - 8; j++) begin
      sa = step(sa);
      sb = step(sb);
    end
    return {sa & ma, sb & mb};
  endfunction

  // k = edges since the last reset edge (0 = the reset edge itself)
  function automatic exp_t model(input int aw, input int bw, input int nr, input int rc, input int kk);
    exp_t e;
    int n;
    e = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    if (kk < rc) return e;
    e.resetn = 1'b1;
    n = kk - rc;
    if (n < 8 + nr) begin
      {e.a, e.b} = vec(aw, bw, n);
      e.valid = 1'b1;
    end else begin
      {e.a, e.b} = vec(aw, bw, 8 + nr - 1);
      e.done = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
    armed <= armed | rst;
  end

  always @(negedge clk) begin
    exp_t e0, e1;
    if (armed) begin
      e0 = model(8, 8, NR0, RC0, k);
      chk("d0_resetn", {31'h0, if0.o_resetn}, {31'h0, e0.resetn});
      chk("d0_valid",  {31'h0, if0.o_valid},  {31'h0, e0.valid});
      chk("d0_done",   {31'h0, if0.o_done},   {31'h0, e0.done});
      chk("d0_op_a",   {24'h0, if0.op_a},     e0.a);
      chk("d0_op_b",   {24'h0, if0.op_b},     e0.b);
      e1 = model(4, 12, NR1, RC1, k);
      chk("d1_resetn", {31'h0, if1.o_resetn}, {31'h0, e1.resetn});
      chk("d1_valid",  {31'h0, if1.o_valid},  {31'h0, e1.valid});
      chk("d1_done",   {31'h0, if1.o_done},   {31'h0, e1.done});
      chk("d1_op_a",   {28'h0, if1.op_a},     e1.a);
      chk("d1_op_b",   {20'h0, if1.op_b},     e1.b);
      if (k == 0) begin
        vcnt0 = 0;
        vcnt1 = 0;
      end
      if (if0.o_valid === 1'b1) vcnt0++;
      if (if1.o_valid === 1'b1) vcnt1++;
    end
  end

  initial begin
    exp_t e;
    // hand-computed anchors for the model itself
    chk("lit_step_a", step(32'h0000_0001), 32'h8020_0003);
    chk("lit_step_b", step(32'h0000_ACE1), 32'h8020_5673);
    e = model(8, 8, NR0, RC0, RC0 - 1);
    chk("lit_hold_resetn", {31'h0, e.resetn}, 32'h0);
    e = model(8, 8, NR0, RC0, RC0 + 3);
    chk("lit_dir3", {e.a[15:0], e.b[15:0]}, 32'h00FF_0000);
    e = model(8, 8, NR0, RC0, RC0 + 6);
    chk("lit_dir6", {e.a[15:0], e.b[15:0]}, 32'h0001_00FF);
    e = model(8, 8, NR0, RC0, RC0 + 8);
    chk("lit_rnd0", {e.a[15:0], e.b[15:0]}, 32'h0001_00E1);
    e = model(8, 8, NR0, RC0, RC0 + 9);
    chk("lit_rnd1", {e.a[15:0], e.b[15:0]}, 32'h0003_0073);
    e = model(4, 12, NR1, RC1, RC1 + 7);
    chk("lit_w_max", {e.a[15:0], e.b[15:0]}, 32'h000F_0FFF);
    e = model(4, 12, NR1, RC1, RC1 + 8);
    chk("lit_w_rnd0", {e.a[15:0], e.b[15:0]}, 32'h0001_0CE1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (RC0 + 8 + 20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (RC0 + 8 + NR0 + 10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("d0_valid_cycles", vcnt0, 32'd72);
    chk("d1_valid_cycles", vcnt1, 32'd13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tester_ex1_2_stim.md
Name: tester_ex1_2_stim

Overview:
Self-running stimulus generator for the exercise 1-2 unsigned adder bench.
- Produces an active-low reset for the adder DUT.
- Then drives a fixed directed corner-case sequence of operand pairs, followed by a pseudo-random sequence.
- Sits beside the adder in the top-level bench and is driven only by the bench clock and reset.

Parameters:
A, 8, width of operand op_a (1..32)
B, 8, width of operand op_b (1..32)
ADDER_0, A+1, width of the downstream adder sum; informational, no effect on generated values
RST_CYCLES, 4, cycles o_resetn is held low after i_reset deasserts (>=1)
NUM_RANDOM, 64, number of pseudo-random operand pairs (>=1)
SEED_A, 32'h0000_0001, initial LFSR state for op_a (nonzero)
SEED_B, 32'h0000_ACE1, initial LFSR state for op_b (nonzero)

Ports:
i_clk  input  1  bench clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
o_resetn  output  1  active-low reset for the adder DUT
op_a  output  A  operand A
op_b  output  B  operand B
o_valid  output  1  high while op_a/op_b hold a new vector
o_done  output  1  high once all vectors have been issued

Behaviour:
General
- One clock, i_clk.
- Reset is synchronous and active-high (i_reset).
- All outputs are registered.

Reset
- While i_reset=1 at an edge, the registers load: state=HOLD, counter=0, o_resetn=0, op_a=0, op_b=0, o_valid=0, o_done=0, lfsr_a=SEED_A, lfsr_b=SEED_B.
- Asserting i_reset in any state returns to this condition on the next edge.

FSM states: HOLD -> DIRECTED -> RANDOM -> DONE.

HOLD
- o_resetn=0.
- Counts RST_CYCLES edges after i_reset deasserts.
- On the last count edge: o_resetn becomes 1, directed vector 0 is loaded, o_valid=1, state moves to DIRECTED.

DIRECTED
- One vector per cycle, in this order (MA, MB = all-ones of width A, B): (0,0), (0,1), (1,0), (MA,0), (0,MB), (MA,1), (1,MB), (MA,MB).
- After vector 7 has been held one cycle, the first random vector is loaded and state moves to RANDOM.

RANDOM
- Two independent 32-bit Galois LFSRs.
  - Step rule: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
  - Polynomial: x^32+x^22+x^2+x+1.
- Each random vector presents op_a = lfsr_a[A-1:0] and op_b = lfsr_b[B-1:0] from the current state; both LFSRs then advance once.
- The first random vector therefore uses the seeds.
- NUM_RANDOM vectors are issued, one per cycle.

DONE
- Entered after the last random vector has been held one cycle.
- o_valid=0, o_done=1.
- op_a/op_b keep the last random values.
- o_resetn stays 1.
- Stays in DONE until i_reset.

Timing and invariants
- o_valid is 1 continuously from o_resetn rising until DONE.
- Total valid cycles = 8 + NUM_RANDOM.
- No handshake and no backpressure; the generator never stalls.
- The LFSRs never reach zero given nonzero seeds.

Test Plan:
1. i_reset=1 for 3 cycles, then 0 -> o_resetn=0, op_a=op_b=0, o_valid=0 during reset and the 4 following edges; o_resetn=1 and o_valid=1 from the 4th edge after release.
2. Defaults, after release -> directed sequence (00,00), (00,01), (01,00), (FF,00), (00,FF), (FF,01), (01,FF), (FF,FF) on 8 consecutive cycles.
3. Random phase, defaults -> first pair (01,E1); second pair (03,73); LFSR states 0x80200003 and 0x80205673 after the first step.
4. Count o_valid cycles -> exactly 72; o_done rises on the edge o_valid falls; op values then frozen.
5. Assert i_reset for 1 cycle mid-RANDOM -> next edge shows o_resetn=0, outputs 0; the full sequence then replays identically, including the random values.
6. A=4, B=12 -> directed maxima 0xF / 0xFFF; first random pair (0x1, 0xCE1); o_done after 8+NUM_RANDOM valid cycles.
